// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the FIFO pointer/flag controller.
//   ptr_inc     - pointer increment with explicit wrap at depth-1 (any depth >= 2)
//   addr_width  - pointer/count width able to hold 0..depth
//   ERR_*_BIT   - error-flag bit positions shared with the UART status register
package fifo_pkg;

  localparam int unsigned ERR_OVF_BIT = 0;
  localparam int unsigned ERR_UDF_BIT = 1;

  // Count must reach depth itself, hence depth+1 codes.
  function automatic int unsigned addr_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Depth need not be a power of two, so the wrap is a compare, not a modulo.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: pointer and flag controller for a single-clock dual-port FIFO buffer.
// Ports:
//   clk_i, rstn_i            clock, async active-low reset
//   push_i, pop_i            write / read requests
//   flush_i                  synchronous clear of pointers and count
//   clr_err_i                clears sticky ovf_o / udf_o
//   buf_wren_o, buf_rden_o   accepted push / pop (buffer enables)
//   buf_wr_ptr_o/rd_ptr_o    registered buffer addresses
//   rd_valid_o               one cycle after an accepted pop (buffer read latency)
//   full_o, empty_o, count_o occupancy status
//   ovf_o, udf_o             sticky overflow / underflow
// Optional (macro FIFO_PTR_CTRL_ALMOST_EN): AF_THRESH / AE_THRESH parameters and
// registered almost_full_o / almost_empty_o outputs.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 50,
`ifdef FIFO_PTR_CTRL_ALMOST_EN
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2,
`endif
  localparam int unsigned ADDR_WIDTH = addr_width(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic                  clr_err_i,
  output logic                  buf_wren_o,
  output logic                  buf_rden_o,
  output logic [ADDR_WIDTH-1:0] buf_wr_ptr_o,
  output logic [ADDR_WIDTH-1:0] buf_rd_ptr_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH-1:0] count_o,
`ifdef FIFO_PTR_CTRL_ALMOST_EN
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
`endif
  output logic                  ovf_o,
  output logic                  udf_o
);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  full, empty, push_acc, pop_acc, ovf_set, udf_set;

  assign full     = (count_q == ADDR_WIDTH'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push_acc = push_i & ~full & ~flush_i;
  assign pop_acc  = pop_i & ~empty & ~flush_i;
  assign ovf_set  = push_i & full & ~flush_i;
  assign udf_set  = pop_i & empty & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = ADDR_WIDTH'(ptr_inc(32'(wr_ptr_q), FIFO_DEPTH));
      if (pop_acc)  rd_ptr_d = ADDR_WIDTH'(ptr_inc(32'(rd_ptr_q), FIFO_DEPTH));
      unique case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Set beats clear when both happen in the same cycle.
  assign ovf_d      = ovf_set | (ovf_q & ~clr_err_i);
  assign udf_d      = udf_set | (udf_q & ~clr_err_i);
  assign rd_valid_d = pop_acc;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

`ifdef FIFO_PTR_CTRL_ALMOST_EN
  logic almost_full_q, almost_empty_q;

  // Registered from count_d so the flags change in the same cycle as count_o.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (32'(count_d) >= AF_THRESH);
      almost_empty_q <= (32'(count_d) <= AE_THRESH);
    end
  end

  assign almost_full_o  = almost_full_q;
  assign almost_empty_o = almost_empty_q;
`endif

  assign buf_wren_o   = push_acc;
  assign buf_rden_o   = pop_acc;
  assign buf_wr_ptr_o = wr_ptr_q;
  assign buf_rd_ptr_o = rd_ptr_q;
  assign rd_valid_o   = rd_valid_q;
  assign full_o       = full;
  assign empty_o      = empty;
  assign count_o      = count_q;
  assign ovf_o        = ovf_q;
  assign udf_o        = udf_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb_fifo_ptr_ctrl: directed self-checking bench for fifo_ptr_ctrl (FIFO_DEPTH = 50).
module tb_fifo_ptr_ctrl;

  localparam int unsigned Depth = 50;
  localparam int unsigned Aw    = 6;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          push_i, pop_i, flush_i, clr_err_i;
  logic          buf_wren_o, buf_rden_o, rd_valid_o, full_o, empty_o, ovf_o, udf_o;
  logic [Aw-1:0] buf_wr_ptr_o, buf_rd_ptr_o, count_o;

  int checks   = 0;
  int failures = 0;

  fifo_ptr_ctrl #(.FIFO_DEPTH(Depth)) u_dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (push_i),
    .pop_i       (pop_i),
    .flush_i     (flush_i),
    .clr_err_i   (clr_err_i),
    .buf_wren_o  (buf_wren_o),
    .buf_rden_o  (buf_rden_o),
    .buf_wr_ptr_o(buf_wr_ptr_o),
    .buf_rd_ptr_o(buf_rd_ptr_o),
    .rd_valid_o  (rd_valid_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .count_o     (count_o),
    .ovf_o       (ovf_o),
    .udf_o       (udf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic push, input logic pop, input logic flush, input logic clr);
    push_i    = push;
    pop_i     = pop;
    flush_i   = flush;
    clr_err_i = clr;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle();
  endtask

  initial begin
    int unsigned errs;
    rstn_i = 1'b0;
    idle();
    #12;
    // Reset state
    check_eq("rst_count", count_o, 0);
    check_eq("rst_empty", empty_o, 1);
    check_eq("rst_full", full_o, 0);
    check_eq("rst_wren", buf_wren_o, 0);
    check_eq("rst_rden", buf_rden_o, 0);
    check_eq("rst_wrptr", buf_wr_ptr_o, 0);
    check_eq("rst_rdptr", buf_rd_ptr_o, 0);
    check_eq("rst_rdvalid", rd_valid_o, 0);
    check_eq("rst_ovf", ovf_o, 0);
    check_eq("rst_udf", udf_o, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();

    // 50 pushes, pointer walks 0..49 then wraps
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      if (buf_wren_o !== 1'b1 || buf_wr_ptr_o !== Aw'(i)) errs++;
      tick();
    end
    check_eq("fill_wr_seq_errs", errs, 0);
    check_eq("fill_count", count_o, 50);
    check_eq("fill_full", full_o, 1);
    check_eq("fill_wrptr_wrap", buf_wr_ptr_o, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("push_full_wren", buf_wren_o, 0);
    tick();
    idle();
    check_eq("push_full_ovf", ovf_o, 1);
    check_eq("push_full_count", count_o, 50);

    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    check_eq("clr_ovf", ovf_o, 0);

    // 50 pops, rd_valid one cycle after each
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      if (buf_rden_o !== 1'b1 || buf_rd_ptr_o !== Aw'(i)) errs++;
      tick();
      if (rd_valid_o !== 1'b1) errs++;
    end
    idle();
    check_eq("drain_seq_errs", errs, 0);
    check_eq("drain_empty", empty_o, 1);
    check_eq("drain_rdptr_wrap", buf_rd_ptr_o, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("pop_empty_rden", buf_rden_o, 0);
    tick();
    idle();
    check_eq("pop_empty_udf", udf_o, 1);
    check_eq("pop_empty_rdvalid", rd_valid_o, 0);
    check_eq("pop_empty_count", count_o, 0);

    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    check_eq("clr_udf", udf_o, 0);

    // Count 10 then push+pop for 100 cycles (pointers start at 0)
    push_n(10);
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      if (buf_wren_o !== 1'b1 || buf_rden_o !== 1'b1) errs++;
      tick();
      if (count_o !== Aw'(10)) errs++;
    end
    idle();
    check_eq("steady_errs", errs, 0);
    check_eq("steady_wrptr", buf_wr_ptr_o, 10);
    check_eq("steady_rdptr", buf_rd_ptr_o, 0);
    check_eq("steady_ovf", ovf_o, 0);
    check_eq("steady_udf", udf_o, 0);

    // Full plus push+pop: pop wins, overflow flagged
    push_n(40);
    check_eq("full2_count", count_o, 50);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("fullpp_wren", buf_wren_o, 0);
    check_eq("fullpp_rden", buf_rden_o, 1);
    tick();
    idle();
    check_eq("fullpp_count", count_o, 49);
    check_eq("fullpp_ovf", ovf_o, 1);

    // Flush then clear errors, then empty plus push+pop
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    check_eq("flush1_count", count_o, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("emptypp_wren", buf_wren_o, 1);
    check_eq("emptypp_rden", buf_rden_o, 0);
    tick();
    idle();
    check_eq("emptypp_count", count_o, 1);
    check_eq("emptypp_udf", udf_o, 1);
    check_eq("emptypp_ovf", ovf_o, 0);

    // Count 20, flush with push: no write, no new error, udf kept
    push_n(19);
    check_eq("cnt20", count_o, 20);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("flush_wren", buf_wren_o, 0);
    tick();
    idle();
    check_eq("flush_count", count_o, 0);
    check_eq("flush_wrptr", buf_wr_ptr_o, 0);
    check_eq("flush_rdptr", buf_rd_ptr_o, 0);
    check_eq("flush_ovf", ovf_o, 0);
    check_eq("flush_udf", udf_o, 1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    check_eq("clr_vs_set_udf", udf_o, 1);

    // Async reset mid-burst at count 30
    push_n(30);
    check_eq("cnt30", count_o, 30);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rstn_i = 1'b0;
    #1;
    check_eq("async_rst_count", count_o, 0);
    check_eq("async_rst_wrptr", buf_wr_ptr_o, 0);
    check_eq("async_rst_empty", empty_o, 1);
    check_eq("async_rst_udf", udf_o, 0);
    idle();
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("post_rst_wren", buf_wren_o, 1);
    check_eq("post_rst_wraddr", buf_wr_ptr_o, 0);
    tick();
    idle();
    check_eq("post_rst_count", count_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
